// File: rtl/regwb_pkg.sv
// ---------------------------------------------------------------------------
// regwb_pkg
// Shared definitions for the register write-back controller: FSM state
// encoding, instruction classes, destination-mux selector codes and the
// opcode/funct values the decoder recognises, plus the classification
// function used by the controller's DECODE step.
// ---------------------------------------------------------------------------
package regwb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_WRITE  = 2'd3
  } regwb_state_e;

  // Write-back behaviour of an instruction, derived from opcode/funct.
  typedef enum logic [2:0] {
    CLS_NONE   = 3'd0,
    CLS_MULDIV = 3'd1,
    CLS_RD     = 3'd2,
    CLS_RT     = 3'd3,
    CLS_JAL    = 3'd4
  } regwb_class_e;

  // Destination-mux selector codes. SEL_R16 is reserved and never produced
  // by decode.
  localparam logic [2:0] SEL_RT  = 3'b000;
  localparam logic [2:0] SEL_R16 = 3'b001;
  localparam logic [2:0] SEL_RD  = 3'b010;
  localparam logic [2:0] SEL_RA  = 3'b011;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_DIV  = 6'h1A;

  // Maps an instruction onto its write-back class. jr and unknown opcodes
  // fall into CLS_NONE (no write, immediate completion).
  function automatic regwb_class_e classify(input logic [5:0] opcode,
                                            input logic [5:0] funct);
    regwb_class_e cls;
    cls = CLS_NONE;
    case (opcode)
      OP_SPECIAL: begin
        if (funct == FN_JR) begin
          cls = CLS_NONE;
        end else if ((funct == FN_MULT) || (funct == FN_DIV)) begin
          cls = CLS_MULDIV;
        end else begin
          cls = CLS_RD;
        end
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_LUI, OP_LW: cls = CLS_RT;
      OP_JAL:  cls = CLS_JAL;
      default: cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/regwb_ctrl_if.sv
// ---------------------------------------------------------------------------
// regwb_ctrl_if
// Bundles the request, producer handshake and write-back outputs of the
// write-back controller.
//   master : main control / producer side (drives start, opcode, funct,
//            result_valid, abort; observes the outputs)
//   slave  : the controller (regwb_ctrl)
// ---------------------------------------------------------------------------
interface regwb_ctrl_if;

  logic       start;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       result_valid;
  logic       abort;
  logic [2:0] reg_dst_sel;
  logic       reg_write;
  logic       busy;
  logic       done;
  logic       timeout_err;

  modport master (
    output start, opcode, funct, result_valid, abort,
    input  reg_dst_sel, reg_write, busy, done, timeout_err
  );

  modport slave (
    input  start, opcode, funct, result_valid, abort,
    output reg_dst_sel, reg_write, busy, done, timeout_err
  );

endinterface

// File: rtl/regwb_watchdog.sv
// ---------------------------------------------------------------------------
// regwb_watchdog
// Counts consecutive enabled cycles and flags the LIMIT-th one. Used by
// regwb_ctrl only when REGWB_TIMEOUT_EN is defined.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clear      : forces the count back to zero
//   enable     : counts this cycle
//   expired    : high during the LIMIT-th consecutive enabled cycle
// ---------------------------------------------------------------------------
module regwb_watchdog #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned   W    = $clog2(LIMIT + 1);
  localparam logic [W-1:0]  LAST = W'(LIMIT - 1);

  logic [W-1:0] count_q, count_d;

  // count_q holds the number of enabled cycles already completed, so it
  // reads LAST while the LIMIT-th cycle is in progress.
  assign expired = enable && (count_q == LAST);

  // Counter next value: clear wins, and it saturates once expired so it
  // can never wrap if the owner keeps it enabled.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/regwb_ctrl.sv
// ---------------------------------------------------------------------------
// regwb_ctrl
// Multicycle write-back controller for the register-file destination path.
// On start it latches opcode/funct, classifies them in DECODE, drives the
// destination-mux selector, waits for the producing unit where needed and
// issues exactly one reg_write pulse (or a bare done pulse for instructions
// that write no GPR).
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   bus.start         : request, sampled only in IDLE with opcode/funct
//   bus.result_valid  : producer result ready, sampled only in WAIT
//   bus.abort         : cancel back to IDLE, highest priority
//   bus.reg_dst_sel   : destination-mux selector (registered)
//   bus.reg_write     : register-file write enable (registered)
//   bus.busy          : high in every state but IDLE (registered)
//   bus.done          : one-cycle completion pulse (registered)
//   bus.timeout_err   : one-cycle watchdog pulse (registered)
// Configuration:
//   REGWB_TIMEOUT_EN  : when defined, WAIT is abandoned after TIMEOUT_CYCLES
//                       cycles without result_valid; otherwise WAIT is
//                       unbounded and timeout_err stays 0.
// ---------------------------------------------------------------------------
module regwb_ctrl
  import regwb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic          clk,
  input  logic          reset,
  regwb_ctrl_if.slave   bus
);

  regwb_state_e state_q, state_d;
  regwb_class_e cls;
  logic [5:0]   opcode_q, opcode_d;
  logic [5:0]   funct_q, funct_d;
  logic [2:0]   reg_dst_sel_q, reg_dst_sel_d;
  logic         reg_write_q, reg_write_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         timeout_err_q, timeout_err_d;
  logic         done_fire;
  logic         timeout_fire;
  logic         wd_expired;

`ifdef REGWB_TIMEOUT_EN
  // The watchdog is held cleared outside WAIT, so every entry into WAIT
  // starts a fresh count.
  regwb_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q != ST_WAIT),
    .enable  (state_q == ST_WAIT),
    .expired (wd_expired)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign wd_expired         = 1'b0;
`endif

  // Next-state and next-output logic. Outputs are derived from the state
  // being entered so that, once registered, reg_write/done/busy line up
  // with the state they describe. Within WAIT the priority is abort, then
  // result_valid, then watchdog expiry.
  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    funct_d       = funct_q;
    reg_dst_sel_d = reg_dst_sel_q;
    done_fire     = 1'b0;
    timeout_fire  = 1'b0;
    cls           = classify(opcode_q, funct_q);

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          opcode_d = bus.opcode;
          funct_d  = bus.funct;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else begin
          case (cls)
            CLS_MULDIV: state_d = ST_WAIT;
            CLS_RD: begin
              reg_dst_sel_d = SEL_RD;
              state_d       = ST_WAIT;
            end
            CLS_RT: begin
              reg_dst_sel_d = SEL_RT;
              state_d       = ST_WAIT;
            end
            CLS_JAL: begin
              reg_dst_sel_d = SEL_RA;
              state_d       = ST_WRITE;
            end
            default: begin
              done_fire = 1'b1;
              state_d   = ST_IDLE;
            end
          endcase
        end
      end
      ST_WAIT: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (bus.result_valid) begin
          if (cls == CLS_MULDIV) begin
            done_fire = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            state_d = ST_WRITE;
          end
        end else if (wd_expired) begin
          timeout_fire = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    reg_write_d   = (state_d == ST_WRITE);
    done_d        = done_fire || (state_d == ST_WRITE);
    busy_d        = (state_d != ST_IDLE);
    timeout_err_d = timeout_fire;
  end

  // State and output registers. Reset may arrive mid-operation; it drops
  // every output immediately and returns to IDLE, so no write can follow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      opcode_q      <= '0;
      funct_q       <= '0;
      reg_dst_sel_q <= SEL_RT;
      reg_write_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      funct_q       <= funct_d;
      reg_dst_sel_q <= reg_dst_sel_d;
      reg_write_q   <= reg_write_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.reg_dst_sel = reg_dst_sel_q;
  assign bus.reg_write   = reg_write_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.timeout_err = timeout_err_q;

endmodule
